char_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 8 +
 rtl/vga_pkg.sv | 5 +
 rtl/frame_tick_gen.sv | 25 ++
 rtl/char_ctrl.sv | 110 +++++++++++
 tb/tb_char_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game types, ground line margin and frame timing helper
package game_pkg;
  typedef enum logic [1:0] {GROUND, RISING, FALLING} char_state_t;
  localparam int GROUND_MARGIN = 52;
  function automatic int frame_ticks(input int clk_hz, input int frame_rate);
    return clk_hz / frame_rate;
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: visible display geometry shared by all draw stages
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle registered pulse every CLK_HZ/FRAME_RATE cycles
module frame_tick_gen
  import game_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int FRAME_RATE = 60
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);
  localparam int FT = frame_ticks(CLK_HZ, FRAME_RATE);
  localparam int W = FT > 1 ? $clog2(FT) : 1;
  localparam logic [W-1:0] LAST = W'(FT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      frame_tick <= cnt == LAST;
    end
  end
endmodule

// File: rtl/char_ctrl.sv
// char_ctrl: per-frame walk and gravity jump of the player sprite, clamped to the play field
module char_ctrl
  import game_pkg::*;
  import vga_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int FRAME_RATE = 60,
  parameter int CHAR_LNG   = 24,
  parameter int CHAR_HGT   = 32,
  parameter int MOVE_STEP  = 4,
  parameter int JUMP_V     = 20,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] char_x,
  output logic [11:0] char_y,
  output logic        char_dir,
  output logic        on_ground,
  output logic        frame_tick
);
  localparam logic signed [12:0] GROUND_Y_S = 13'(VER_PIXELS - GROUND_MARGIN - CHAR_HGT);
  localparam logic signed [12:0] X_MIN_S = 13'(CHAR_LNG);
  localparam logic signed [12:0] X_MAX_S = 13'(HOR_PIXELS - 1 - CHAR_LNG);
  localparam logic signed [12:0] Y_MIN_S = 13'(CHAR_HGT);
  localparam logic signed [12:0] STEP_S = 13'(MOVE_STEP);
  localparam logic signed [12:0] GRAV_S = 13'(GRAVITY);
  localparam logic signed [12:0] MAXF_S = 13'(MAX_FALL);
  localparam logic [11:0] X_RST = 12'(HOR_PIXELS * 3 / 4);
  localparam logic [5:0] JUMP_VEL = 6'(JUMP_V);
  char_state_t state;
  logic [5:0] vel;
  logic jump_pending, jump_q;
  logic signed [12:0] xs, ys, vs, x_l, x_r, y_up, v_inc, v_fall, y_dn;
  logic [11:0] x_l_c, x_r_c;
  logic go_l, go_r, upd;
  frame_tick_gen #(.CLK_HZ(CLK_HZ), .FRAME_RATE(FRAME_RATE)) u_tick (
    .clk(clk), .rst(rst), .frame_tick(frame_tick)
  );
  // 13-bit signed intermediates keep every subtraction from wrapping
  assign xs = {1'b0, char_x};
  assign ys = {1'b0, char_y};
  assign vs = {7'b0, vel};
  assign x_l = xs - STEP_S;
  assign x_r = xs + STEP_S;
  assign y_up = ys - vs;
  assign v_inc = vs + GRAV_S;
  assign v_fall = v_inc > MAXF_S ? MAXF_S : v_inc;
  assign y_dn = ys + v_fall;
  assign x_l_c = x_l < X_MIN_S ? X_MIN_S[11:0] : x_l[11:0];
  assign x_r_c = x_r > X_MAX_S ? X_MAX_S[11:0] : x_r[11:0];
  assign go_l = btn_left & ~btn_right;
  assign go_r = btn_right & ~btn_left;
  assign upd = frame_tick & game_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      char_x <= X_RST;
      char_y <= GROUND_Y_S[11:0];
      char_dir <= 1'b1;
      on_ground <= 1'b1;
      state <= GROUND;
      vel <= '0;
      jump_pending <= 1'b0;
      jump_q <= 1'b0;
    end else begin
      jump_q <= btn_jump;
      jump_pending <= ~frame_tick & (jump_pending | (btn_jump & ~jump_q));
      if (upd) begin
        if (go_l) begin
          char_x <= x_l_c;
          char_dir <= 1'b0;
        end else if (go_r) begin
          char_x <= x_r_c;
          char_dir <= 1'b1;
        end
        case (state)
          GROUND: if (jump_pending) begin
            state <= RISING;
            vel <= JUMP_VEL;
            on_ground <= 1'b0;
          end
          RISING: if (y_up < Y_MIN_S) begin
            char_y <= Y_MIN_S[11:0];
            vel <= '0;
            state <= FALLING;
          end else begin
            char_y <= y_up[11:0];
            state <= vs <= GRAV_S ? FALLING : RISING;
            vel <= vs <= GRAV_S ? '0 : vel - GRAV_S[5:0];
          end
          FALLING: if (y_dn >= GROUND_Y_S) begin
            char_y <= GROUND_Y_S[11:0];
            vel <= '0;
            state <= GROUND;
            on_ground <= 1'b1;
          end else begin
            char_y <= y_dn[11:0];
            vel <= v_fall[5:0];
          end
          default: state <= GROUND;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_char_ctrl.sv
// tb_char_ctrl: table vectors, corner sequences and a per-cycle reference model for char_ctrl
module tb_char_ctrl;
  logic clk = 0, rst = 1, game_en = 0, btn_left = 0, btn_right = 0, btn_jump = 0;
  logic [11:0] char_x, char_y;
  logic char_dir, on_ground, frame_tick;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;

  char_ctrl #(.CLK_HZ(600), .FRAME_RATE(60)) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .btn_left(btn_left), .btn_right(btn_right),
    .btn_jump(btn_jump), .char_x(char_x), .char_y(char_y), .char_dir(char_dir),
    .on_ground(on_ground), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // reference model: airborne physics as signed ints, frame timing from cycle count
  int m_x = 768, m_y = 684, m_vel = 0, m_cnt = 0;
  bit m_air = 0, m_up = 0, m_dir = 1, m_pend = 0, m_prev = 0, m_tick = 0;
  always @(posedge clk) begin
    int v;
    if (rst) begin
      m_x = 768; m_y = 684; m_vel = 0; m_cnt = 0;
      m_air = 0; m_up = 0; m_dir = 1; m_pend = 0; m_prev = 0; m_tick = 0;
    end else begin
      if (m_tick && game_en) begin
        if (btn_left && !btn_right) begin m_dir = 0; m_x = m_x - 4 < 24 ? 24 : m_x - 4; end
        if (btn_right && !btn_left) begin m_dir = 1; m_x = m_x + 4 > 999 ? 999 : m_x + 4; end
        if (!m_air) begin
          if (m_pend) begin m_air = 1; m_up = 1; m_vel = 20; end
        end else if (m_up) begin
          if (m_y - m_vel < 32) begin m_y = 32; m_vel = 0; m_up = 0; end
          else begin
            m_y = m_y - m_vel;
            if (m_vel <= 1) begin m_vel = 0; m_up = 0; end else m_vel = m_vel - 1;
          end
        end else begin
          v = m_vel + 1 > 16 ? 16 : m_vel + 1;
          if (m_y + v >= 684) begin m_y = 684; m_vel = 0; m_air = 0; end
          else begin m_y = m_y + v; m_vel = v; end
        end
      end
      m_pend = m_tick ? 0 : (m_pend || (btn_jump && !m_prev));
      m_prev = btn_jump;
      m_cnt++;
      m_tick = (m_cnt % 10) == 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_on)
      check("model", {char_x, char_y, char_dir, on_ground, frame_tick},
            {12'(m_x), 12'(m_y), m_dir, !m_air, m_tick});

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(negedge clk);
      seen = frame_tick;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL tick_timeout: got no frame_tick expected one within 25 cycles");
    end
  endtask

  task automatic frames(input int n);
    repeat (n) wait_tick();
    @(negedge clk);
  endtask

  task automatic first_tick(input string name);
    int c = 0;
    bit seen = 0;
    for (int i = 1; i <= 25 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) begin seen = 1; c = i; end
    end
    check(name, 64'(c), 64'd10);
  endtask

  typedef struct {
    logic l, r, j, en;
    int n, x, y;
    logic dir, gnd;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{0, 0, 0, 1,   5, 768, 684, 1, 1};
    tbl[1]  = '{0, 1, 0, 1,  57, 996, 684, 1, 1};
    tbl[2]  = '{0, 1, 0, 1,   1, 999, 684, 1, 1};
    tbl[3]  = '{0, 1, 0, 1,   3, 999, 684, 1, 1};
    tbl[4]  = '{1, 0, 0, 1,   1, 995, 684, 0, 1};
    tbl[5]  = '{1, 1, 0, 1,  10, 995, 684, 0, 1};
    tbl[6]  = '{0, 0, 1, 1,   1, 995, 684, 0, 0};
    tbl[7]  = '{0, 0, 1, 1,  20, 995, 474, 0, 0};
    tbl[8]  = '{0, 0, 1, 1,  21, 995, 684, 0, 1};
    tbl[9]  = '{0, 0, 1, 1, 100, 995, 684, 0, 1};
    tbl[10] = '{0, 0, 0, 1,   1, 995, 684, 0, 1};
    tbl[11] = '{1, 0, 0, 1, 300,  24, 684, 0, 1};
    tbl[12] = '{0, 1, 0, 0,   5,  24, 684, 0, 1};
    @(posedge clk);
    chk_on = 1;
    repeat (2) @(negedge clk);
    check("reset_state", {char_x, char_y, char_dir, on_ground, frame_tick},
          {12'd768, 12'd684, 1'b1, 1'b1, 1'b0});
    rst = 0; game_en = 1;
    first_tick("first_tick");
    @(negedge clk);
    foreach (tbl[k]) begin
      btn_left = tbl[k].l; btn_right = tbl[k].r; btn_jump = tbl[k].j; game_en = tbl[k].en;
      frames(tbl[k].n);
      check($sformatf("vec%0d", k), {char_x, char_y, char_dir, on_ground},
            {12'(tbl[k].x), 12'(tbl[k].y), tbl[k].dir, tbl[k].gnd});
    end
    btn_right = 0; game_en = 1;
    btn_jump = 1;
    frames(6);
    btn_jump = 0;
    check("rise_5", 64'(char_y), 64'd594);
    game_en = 0;
    frames(10);
    check("frozen", {char_x, char_y, on_ground}, {12'd24, 12'd594, 1'b0});
    game_en = 1;
    frames(1);
    check("resume", 64'(char_y), 64'd579);
    frames(7);
    check("rise_502", 64'(char_y), 64'd502);
    rst = 1;
    @(negedge clk);
    check("mid_jump_rst", {char_x, char_y, char_dir, on_ground, frame_tick},
          {12'd768, 12'd684, 1'b1, 1'b1, 1'b0});
    rst = 0;
    first_tick("restart_tick");
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 999) == 0;
      game_en = $urandom_range(0, 9) != 0;
      btn_left = $urandom_range(0, 3) == 0;
      btn_right = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 29) == 0) btn_jump = ~btn_jump;
    end
    rst = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
